// File: rtl/pll_cfg_sel_pkg.sv
// Shared types for the PLL configuration selector: FSM state encoding,
// config index width and the wrap/saturate index step helper.
package pll_cfg_sel_pkg;

    localparam int PLL_ADDR_W = 8;

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_REQ,
        S_BLANK,
        S_WAIT
    } state_t;

    // Bounds are tested before the +/-1, so an index at 8'hFF or 8'h00 never rolls over.
    function automatic logic [PLL_ADDR_W-1:0] step_idx(
        input logic [PLL_ADDR_W-1:0] idx,
        input logic                  up,
        input logic [PLL_ADDR_W-1:0] lo,
        input logic [PLL_ADDR_W-1:0] hi,
        input logic                  wrap
    );
        logic [PLL_ADDR_W-1:0] res;
        if (up) begin
            if (idx >= hi) res = wrap ? lo : hi;
            else           res = idx + PLL_ADDR_W'(1);
        end else begin
            if (idx <= lo) res = wrap ? hi : lo;
            else           res = idx - PLL_ADDR_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pll_cfg_sel_if.sv
// Request bus between the config selector (master) and the PLL DRP stage (slave).
interface pll_cfg_sel_if;
    import pll_cfg_sel_pkg::*;

    logic [PLL_ADDR_W-1:0] PLL_ADDR;
    logic                  PLL_CHG;
    logic                  BUSY;
    logic                  LOCK_ERR;
    logic                  PLL_LOCK;

    modport master (
        output PLL_ADDR,
        output PLL_CHG,
        output BUSY,
        output LOCK_ERR,
        input  PLL_LOCK
    );

    modport slave (
        input  PLL_ADDR,
        input  PLL_CHG,
        input  BUSY,
        input  LOCK_ERR,
        output PLL_LOCK
    );

endinterface

// File: rtl/pll_cfg_sel_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter (2^DEB_W-1 cycles)
// and a one-cycle pulse on each debounced rising edge.
module pll_cfg_sel_btn_debounce #(
    parameter int DEB_W = 16
) (
    input  logic CLK,
    input  logic RSTXO,
    input  logic btn,
    output logic pulse
);

    localparam logic [DEB_W-1:0] CNT_LAST = ~(DEB_W)'(1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [DEB_W-1:0] cnt;

    // Any disagreement with the debounced level restarts the stability count.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + (DEB_W)'(1);
            end
        end
    end

endmodule

// File: rtl/pll_cfg_sel.sv
// PLL config selector: debounced UP/DN step a config index and issue PLL_CHG requests,
// then track relock with a sticky timeout error. Option: PLL_CFG_SEL_AUTOSWEEP_EN.
module pll_cfg_sel
    import pll_cfg_sel_pkg::*;
#(
    parameter logic [PLL_ADDR_W-1:0] ADDR_MIN  = 8'd0,
    parameter logic [PLL_ADDR_W-1:0] ADDR_MAX  = 8'd15,
    parameter logic [PLL_ADDR_W-1:0] ADDR_INIT = 8'd0,
    parameter bit                    WRAP      = 1'b1,
    parameter int                    DEB_W     = 16,
    parameter int                    BLANK_CYC = 64,
    parameter int                    TO_W      = 20
) (
    input  logic CLK,
    input  logic RSTXO,
    input  logic BTN_UP,
    input  logic BTN_DN,
`ifdef PLL_CFG_SEL_AUTOSWEEP_EN
    input  logic SWEEP_EN,
`endif
    pll_cfg_sel_if.master bus
);

    localparam int                 BLANK_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC - 1);

    state_t                state;
    state_t                state_nxt;
    logic [PLL_ADDR_W-1:0] idx;
    logic [PLL_ADDR_W-1:0] idx_nxt;
    logic [PLL_ADDR_W-1:0] cand;
    logic [BLANK_W-1:0]    blank_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [TO_W-1:0]       to_inc;
    logic                  lock_m;
    logic                  lock_s;
    logic                  lock_err;
    logic                  up_pulse;
    logic                  dn_pulse;
    logic                  up_evt;

    pll_cfg_sel_btn_debounce #(.DEB_W(DEB_W)) u_deb_up (
        .CLK   (CLK),
        .RSTXO (RSTXO),
        .btn   (BTN_UP),
        .pulse (up_pulse)
    );

    pll_cfg_sel_btn_debounce #(.DEB_W(DEB_W)) u_deb_dn (
        .CLK   (CLK),
        .RSTXO (RSTXO),
        .btn   (BTN_DN),
        .pulse (dn_pulse)
    );

`ifdef PLL_CFG_SEL_AUTOSWEEP_EN
    // The timeout counter doubles as the sweep timer while idle.
    assign up_evt = up_pulse | (SWEEP_EN & (state == S_IDLE) & (to_cnt == '1));
`else
    assign up_evt = up_pulse;
`endif

    assign to_inc = to_cnt + (TO_W)'(1);
    assign cand   = step_idx(idx, up_evt, ADDR_MIN, ADDR_MAX, WRAP);

    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.PLL_LOCK;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            state <= S_START;
            idx   <= ADDR_INIT;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_START: state_nxt = S_REQ;
            S_IDLE: begin
                if ((up_evt ^ dn_pulse) && (cand != idx)) begin
                    idx_nxt   = cand;
                    state_nxt = S_REQ;
                end
            end
            S_REQ:   state_nxt = S_BLANK;
            S_BLANK: if (blank_cnt == '0) state_nxt = S_WAIT;
            S_WAIT:  if (lock_s || (to_inc == '1)) state_nxt = S_IDLE;
            default: state_nxt = S_START;
        endcase
    end

    // Timeout counter is zeroed on every request and on leaving S_WAIT.
    always_ff @(posedge CLK or negedge RSTXO) begin
        if (!RSTXO) begin
            blank_cnt <= '0;
            to_cnt    <= '0;
            lock_err  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    blank_cnt <= BLANK_LOAD;
                    to_cnt    <= '0;
                end
                S_BLANK: begin
                    if (blank_cnt != '0) blank_cnt <= blank_cnt - BLANK_W'(1);
                    else                 to_cnt    <= '0;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        lock_err <= 1'b0;
                        to_cnt   <= '0;
                    end else if (to_inc == '1) begin
                        lock_err <= 1'b1;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_inc;
                    end
                end
`ifdef PLL_CFG_SEL_AUTOSWEEP_EN
                S_IDLE: to_cnt <= SWEEP_EN ? to_inc : '0;
`endif
                default: ;
            endcase
        end
    end

    assign bus.PLL_ADDR = idx;
    assign bus.PLL_CHG  = (state == S_REQ);
    assign bus.BUSY     = (state != S_IDLE);
    assign bus.LOCK_ERR = lock_err;

endmodule

// File: tb/tb_pll_cfg_sel.sv
// Scoreboard bench for pll_cfg_sel: dut1 wraps over [0,3], dut2 saturates at 3.
// Expected PLL_ADDR values are queued at stimulus time and popped on each PLL_CHG.
module tb_pll_cfg_sel;
    import pll_cfg_sel_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rstxo;
    logic rstxo2;
    logic btn_up;
    logic btn_dn;
    logic btn_up2;
    logic btn_dn2;
    logic lock_manual;
    logic auto_lock;
    logic pll_fail;
    logic lock_auto = 1'b0;
    int   lock_cnt  = 0;

    int tests_run;
    int tests_failed;
    int chg_count;
    int chg_count2;

    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];

    pll_cfg_sel_if bus1();
    pll_cfg_sel_if bus2();

    assign bus1.PLL_LOCK = auto_lock ? lock_auto : lock_manual;
    assign bus2.PLL_LOCK = 1'b1;

    pll_cfg_sel #(
        .ADDR_MIN(8'd0), .ADDR_MAX(8'd3), .ADDR_INIT(8'd0), .WRAP(1'b1),
        .DEB_W(3), .BLANK_CYC(8), .TO_W(6)
    ) dut (
        .CLK(CLK), .RSTXO(rstxo), .BTN_UP(btn_up), .BTN_DN(btn_dn),
`ifdef PLL_CFG_SEL_AUTOSWEEP_EN
        .SWEEP_EN(1'b0),
`endif
        .bus(bus1)
    );

    pll_cfg_sel #(
        .ADDR_MIN(8'd0), .ADDR_MAX(8'd3), .ADDR_INIT(8'd3), .WRAP(1'b0),
        .DEB_W(3), .BLANK_CYC(8), .TO_W(6)
    ) dut2 (
        .CLK(CLK), .RSTXO(rstxo2), .BTN_UP(btn_up2), .BTN_DN(btn_dn2),
`ifdef PLL_CFG_SEL_AUTOSWEEP_EN
        .SWEEP_EN(1'b0),
`endif
        .bus(bus2)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic record_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: got no/extra event, expected the opposite", name);
    endtask

    task automatic apply_stimulus(input logic up, input logic dn, input bit d2);
        if (d2) begin
            btn_up2 = up;
            btn_dn2 = dn;
        end else begin
            btn_up = up;
            btn_dn = dn;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_chg(input bit d2, output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLK);
            if ((d2 ? bus2.PLL_CHG : bus1.PLL_CHG) === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) record_fail("wait_chg_timeout");
    endtask

    task automatic wait_idle(input bit d2);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if ((d2 ? bus2.BUSY : bus1.BUSY) === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) record_fail("wait_idle_timeout");
    endtask

    // PLL model for dut1: lock drops on each request and returns 12 cycles later unless failing.
    always @(negedge CLK) begin
        if (bus1.PLL_CHG === 1'b1) begin
            lock_auto = 1'b0;
            lock_cnt  = 12;
        end else if (lock_cnt > 0) begin
            lock_cnt = lock_cnt - 1;
            if (lock_cnt == 0) lock_auto = ~pll_fail;
        end
    end

    // Monitor: every PLL_CHG must match the next queued address.
    always @(negedge CLK) begin
        if (bus1.PLL_CHG === 1'b1) begin
            chg_count++;
            if (exp_q.size() == 0) record_fail("dut1_unexpected_chg");
            else check_output("dut1_chg_addr", bus1.PLL_ADDR, exp_q.pop_front());
        end
        if (bus2.PLL_CHG === 1'b1) begin
            chg_count2++;
            if (exp_q2.size() == 0) record_fail("dut2_unexpected_chg");
            else check_output("dut2_chg_addr", bus2.PLL_ADDR, exp_q2.pop_front());
        end
    end

    initial begin
        int lat;
        int snap;
        tests_run    = 0;
        tests_failed = 0;
        chg_count    = 0;
        chg_count2   = 0;
        rstxo        = 1'b0;
        rstxo2       = 1'b0;
        btn_up       = 1'b0;
        btn_dn       = 1'b0;
        btn_up2      = 1'b0;
        btn_dn2      = 1'b0;
        lock_manual  = 1'b0;
        auto_lock    = 1'b0;
        pll_fail     = 1'b0;

        wait_cycles(3);
        check_output("rst_addr", bus1.PLL_ADDR, 0);
        check_output("rst_chg", bus1.PLL_CHG, 0);
        check_output("rst_busy", bus1.BUSY, 1);
        check_output("rst_lock_err", bus1.LOCK_ERR, 0);
        check_output("rst_addr_dut2", bus2.PLL_ADDR, 3);

        // Startup request; lock raised 10 cycles after release, 2 sync cycles to reach the FSM.
        exp_q.push_back(8'd0);
        exp_q2.push_back(8'd3);
        rstxo  = 1'b1;
        rstxo2 = 1'b1;
        wait_cycles(10);
        lock_manual = 1'b1;
        wait_cycles(2);
        check_output("startup_busy_before_lock", bus1.BUSY, 1);
        wait_cycles(1);
        check_output("startup_busy_after_lock", bus1.BUSY, 0);
        check_output("startup_lock_err", bus1.LOCK_ERR, 0);
        auto_lock = 1'b1;

        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'((k + 1) % 4));
            apply_stimulus(1'b1, 1'b0, 1'b0);
            wait_chg(1'b0, lat);
            check_output("up_press_latency", lat, 11);
            wait_cycles(9);
            apply_stimulus(1'b0, 1'b0, 1'b0);
            wait_idle(1'b0);
            check_output("up_press_addr", bus1.PLL_ADDR, (k + 1) % 4);
            check_output("up_press_lock_err", bus1.LOCK_ERR, 0);
            wait_cycles(15);
        end

        // Bouncing 0/1 every 2 cycles, then stable high: one request 2+7+2 cycles later.
        exp_q.push_back(8'd1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus((i % 2) == 0, 1'b0, 1'b0);
            wait_cycles(2);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        wait_chg(1'b0, lat);
        check_output("bounce_latency", lat, 11);
        wait_cycles(9);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_idle(1'b0);
        wait_cycles(15);

        // Lock never returns: sticky error when 1+8+63 cycles have passed since the strobe cycle.
        pll_fail = 1'b1;
        exp_q.push_back(8'd2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        wait_chg(1'b0, lat);
        wait_cycles(10);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(61);
        check_output("timeout_busy_before", bus1.BUSY, 1);
        check_output("timeout_err_before", bus1.LOCK_ERR, 0);
        wait_cycles(1);
        check_output("timeout_busy_after", bus1.BUSY, 0);
        check_output("timeout_err_after", bus1.LOCK_ERR, 1);
        check_output("timeout_addr_kept", bus1.PLL_ADDR, 2);
        wait_cycles(15);
        pll_fail = 1'b0;
        exp_q.push_back(8'd3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        wait_chg(1'b0, lat);
        wait_cycles(9);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_idle(1'b0);
        check_output("relock_clears_err", bus1.LOCK_ERR, 0);
        check_output("relock_addr", bus1.PLL_ADDR, 3);
        wait_cycles(15);

        snap = chg_count;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_cycles(20);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(15);
        check_output("both_buttons_no_chg", chg_count - snap, 0);
        check_output("both_buttons_addr", bus1.PLL_ADDR, 3);
        check_output("both_buttons_busy", bus1.BUSY, 0);

        // Saturating instance already at ADDR_MAX: UP is ignored, DN still steps.
        snap = chg_count2;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        wait_cycles(20);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(15);
        check_output("sat_up_no_chg", chg_count2 - snap, 0);
        check_output("sat_up_addr", bus2.PLL_ADDR, 3);
        check_output("sat_up_busy", bus2.BUSY, 0);
        exp_q2.push_back(8'd2);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        wait_chg(1'b1, lat);
        check_output("sat_dn_latency", lat, 11);
        wait_cycles(9);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        wait_idle(1'b1);
        check_output("sat_dn_addr", bus2.PLL_ADDR, 2);

        // Press during blanking is dropped; reset pulse mid-wait restarts from ADDR_INIT.
        pll_fail = 1'b1;
        exp_q.push_back(8'd2);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        wait_chg(1'b0, lat);
        wait_cycles(1);
        snap = chg_count;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        wait_cycles(3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(21);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(5);
        check_output("blank_press_dropped", chg_count - snap, 0);
        check_output("wait_busy", bus1.BUSY, 1);
        check_output("wait_addr", bus1.PLL_ADDR, 2);
        pll_fail = 1'b0;
        rstxo = 1'b0;
        #1;
        check_output("midrst_addr", bus1.PLL_ADDR, 0);
        check_output("midrst_busy", bus1.BUSY, 1);
        check_output("midrst_chg", bus1.PLL_CHG, 0);
        check_output("midrst_lock_err", bus1.LOCK_ERR, 0);
        wait_cycles(2);
        exp_q.push_back(8'd0);
        rstxo = 1'b1;
        wait_chg(1'b0, lat);
        check_output("restart_latency", lat, 1);
        wait_idle(1'b0);
        check_output("restart_addr", bus1.PLL_ADDR, 0);
        check_output("restart_lock_err", bus1.LOCK_ERR, 0);

        wait_cycles(5);
        check_output("dut1_queue_empty", exp_q.size(), 0);
        check_output("dut2_queue_empty", exp_q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
